// File: rtl/sysctrl_pkg.sv
// Shared definitions for the system-control byte protocol: command codes,
// config ids, status magic, frame limits and the command master state encoding.
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS  = 8'd0;
  localparam logic [7:0] CMD_LEDS    = 8'd1;
  localparam logic [7:0] CMD_COLOR   = 8'd2;
  localparam logic [7:0] CMD_BUTTONS = 8'd3;
  localparam logic [7:0] CMD_CONFIG  = 8'd4;
  localparam logic [7:0] CMD_IRQ     = 8'd5;

  localparam logic [7:0] CFG_ID_RESET    = 8'h52;  // "R"
  localparam logic [7:0] CFG_ID_SELFTEST = 8'h53;  // "S"
  localparam logic [7:0] CFG_ID_ADDR     = 8'h41;  // "A"

  localparam logic [7:0] STATUS_MAGIC0 = 8'h5c;
  localparam logic [7:0] STATUS_MAGIC1 = 8'h42;

  // Responder byte counter saturates at 15, so one slot stays in reserve.
  localparam logic [3:0] SYSCTRL_MAX_LEN = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_GAP,
    ST_FETCH,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [3:0] len;
  } frame_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sysctrl_gap_timer.sv
// Strobe pacing counter: load arms GAP cycles, run counts them down; first/expire
// flag the first and last counted cycle. No backpressure, combinational flags.
module sysctrl_gap_timer #(
  parameter int GAP = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic first,
  output logic expire
);

  localparam logic [3:0] GAP_CNT = 4'(GAP);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= GAP_CNT;
    end else if (run && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign first  = run && (cnt == GAP_CNT);
  assign expire = run && (cnt == 4'd1);

endmodule

// File: rtl/sysctrl_cmd_master.sv
// Frames a command byte plus payload onto the responder strobe bus, GAP idle cycles
// between strobes; payload stalls indefinitely on pl_valid, requests wait on req_ready.
module sysctrl_cmd_master
  import sysctrl_pkg::*;
#(
  parameter int         GAP     = 3,
  parameter logic [3:0] MAX_LEN = SYSCTRL_MAX_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [3:0] req_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       done,
  output logic       len_err,
  output logic       busy,
  output logic       out_strobe,
  output logic       out_start,
  output logic [7:0] out_data,
  input  logic [7:0] rsp_in
);

  state_t     state;
  frame_t     frame;
  logic [3:0] k;
  logic [7:0] rsp_q;
  logic       fetch_fire;
  logic       capture;
  logic       tmr_first;
  logic       tmr_expire;

  assign fetch_fire = (state == ST_FETCH) && pl_valid && !reset;
  // k is zero only after the command strobe, which has no reply to capture.
  assign capture    = (state == ST_GAP) && tmr_first && (k != 4'd0) && !reset;

  sysctrl_gap_timer #(.GAP(GAP)) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .load   ((state == ST_CMD) || fetch_fire),
    .run    (state == ST_GAP),
    .first  (tmr_first),
    .expire (tmr_expire)
  );

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign out_start  = (state == ST_CMD);
  assign out_strobe = out_start || fetch_fire;
  assign pl_ready   = fetch_fire;
  assign out_data   = out_start ? frame.cmd : (fetch_fire ? pl_data : 8'h00);
  assign rsp_valid  = capture;
  assign rsp_last   = capture && (k == frame.len);
  assign rsp_data   = capture ? rsp_in : rsp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      frame   <= '0;
      k       <= 4'd0;
      rsp_q   <= 8'h00;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (capture) rsp_q <= rsp_in;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            frame.cmd <= req_cmd;
            frame.len <= clamp_len(req_len, MAX_LEN);
            len_err   <= (req_len > MAX_LEN);
            k         <= 4'd0;
            state     <= ST_CMD;
          end
        end
        ST_CMD:   state <= ST_GAP;
        ST_GAP: begin
          if (tmr_expire) state <= (k == frame.len) ? ST_DONE : ST_FETCH;
        end
        ST_FETCH: begin
          if (fetch_fire) begin
            k     <= k + 4'd1;
            state <= ST_GAP;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
